// File: rtl/mem_pkg.sv
// Shared sizing constants and controller state encoding for the ram512 request path.
package mem_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/ram512_ctrl.sv
// Request front-end for ram512: zero-fills after reset, then serves single-word reads/writes.
// Reads return one cycle after acceptance through a one-deep response slot; req_ready drops while that slot is stalled.
module ram512_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W         = mem_pkg::DATA_W,
  parameter int ADDR_W         = mem_pkg::ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((1 << ADDR_W) - 1);

  ctrl_state_t       r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_clearing;
  logic w_acc;

  assign w_clearing = (r_state == CLEAR);

  // Writes share the read-slot condition so one acceptance rule covers both.
  assign req_ready = !rst && !w_clearing && (!r_rsp_valid || rsp_ready);
  assign w_acc     = req_valid && req_ready;

  assign init_done = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

  assign ram_addr  = w_clearing ? r_clr_cnt : req_addr;
  assign ram_in    = w_clearing ? '0 : req_wdata;
  assign ram_load  = !rst && (w_clearing || (w_acc && req_we));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR_ON_RESET ? CLEAR : IDLE;
      r_clr_cnt   <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          // Counter wraps to 0 naturally on the last word.
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADDR) begin
            r_state <= IDLE;
          end
        end
        IDLE: begin
          if (w_acc && !req_we) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= ram_out;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram512_ctrl.sv
// Directed + randomized bench for ram512_ctrl with a behavioural RAM and a queue-based reference model.
module tb_ram512_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [8:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        init_done;
  logic [15:0] ram_in;
  logic [8:0]  ram_addr;
  logic        ram_load;
  logic [15:0] ram_out;

  always #5 clk = ~clk;

  ram512_ctrl #(.DATA_W(16), .ADDR_W(9), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_in(ram_in), .ram_addr(ram_addr), .ram_load(ram_load), .ram_out(ram_out)
  );

  // Behavioural ram512, with a side port used only to preload junk before the first clear.
  logic [15:0] ram_mem [512];
  logic        fill_en;
  logic [8:0]  fill_addr;
  logic [15:0] fill_dat;

  always @(posedge clk) begin
    if (fill_en) ram_mem[fill_addr] <= fill_dat;
    else if (ram_load) ram_mem[ram_addr] <= ram_in;
  end
  assign ram_out = ram_mem[ram_addr];

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_mem [512];
  logic [15:0] rsp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_ram_load", ram_load, 0);
    @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    rsp_q.delete();
  endtask

  // Runs up to n clear cycles; a full run of 512 leaves the model memory all zero.
  task automatic clear_phase(input int n);
    int bad_rdy = 0, bad_load = 0, bad_addr = 0, bad_in = 0, bad_done = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = 9'($urandom);
      req_wdata = 16'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (req_ready !== 1'b0) bad_rdy++;
      if (ram_load !== 1'b1) bad_load++;
      if (ram_addr !== 9'(i)) bad_addr++;
      if (ram_in !== 16'h0000) bad_in++;
      if (init_done !== 1'b0) bad_done++;
    end
    check("clear_req_ready_low", bad_rdy, 0);
    check("clear_ram_load_high", bad_load, 0);
    check("clear_addr_sequence", bad_addr, 0);
    check("clear_ram_in_zero", bad_in, 0);
    check("clear_init_done_low", bad_done, 0);
    if (n >= 512) begin
      for (int a = 0; a < 512; a++) exp_mem[a] = 16'h0000;
    end
  endtask

  // One IDLE-phase cycle: drive, compare against the model, then advance the model.
  task automatic cycle(input logic v, input logic we, input logic [8:0] a,
                       input logic [15:0] d, input logic rr);
    logic exp_rdy;
    logic acc;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    #1;
    exp_rdy = (rsp_q.size() == 0) || rr;
    check("init_done", init_done, 1);
    check("req_ready", req_ready, exp_rdy);
    check("rsp_valid", rsp_valid, rsp_q.size() != 0);
    if (rsp_q.size() != 0) begin
      check("rsp_rdata", rsp_rdata, rsp_q[0]);
      if (rr) void'(rsp_q.pop_front());
    end
    acc = v && exp_rdy;
    if (acc && we) begin
      check("wr_ram_load", ram_load, 1);
      check("wr_ram_addr", ram_addr, a);
      check("wr_ram_in", ram_in, d);
      exp_mem[a] = d;
    end else begin
      check("ram_load_low", ram_load, 0);
    end
    if (acc && !we) begin
      check("rd_ram_addr", ram_addr, a);
      rsp_q.push_back(exp_mem[a]);
    end
  endtask

  initial begin
    logic [8:0] ra;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    fill_en = 1'b1; fill_addr = '0; fill_dat = '0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      fill_addr = 9'(i);
      fill_dat  = 16'($urandom) | 16'h0001;
    end
    @(negedge clk);
    fill_en = 1'b0;

    // Reset, interrupt the clear at cycle 200, then let a full clear complete.
    do_reset();
    clear_phase(200);
    do_reset();
    clear_phase(512);

    cycle(1, 0, 9'h1FF, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    cycle(1, 1, 9'h0A5, 16'hBEEF, 1);
    cycle(1, 0, 9'h0A5, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    cycle(1, 1, 9'h000, 16'h1111, 1);
    cycle(1, 1, 9'h001, 16'h2222, 1);
    cycle(1, 1, 9'h002, 16'h3333, 1);
    cycle(1, 0, 9'h000, 16'h0, 1);
    cycle(1, 0, 9'h001, 16'h0, 1);
    cycle(1, 0, 9'h002, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    // Stall the response slot for 5 cycles while a write is offered, then release.
    cycle(1, 0, 9'h0A5, 16'h0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 9'h0A5, 16'hDEAD, 0);
    cycle(1, 0, 9'h001, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    cycle(1, 1, 9'h1FF, 16'hFFFF, 1);
    cycle(1, 1, 9'h000, 16'h0001, 1);
    cycle(1, 0, 9'h1FF, 16'h0, 1);
    cycle(1, 0, 9'h000, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 9'h000;
        1: ra = 9'h1FF;
        default: ra = 9'($urandom_range(0, 15));
      endcase
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra,
            16'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    cycle(0, 0, 9'h000, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    // A pending response is dropped by reset, and the RAM is cleared again.
    cycle(1, 0, 9'h1FF, 16'h0, 0);
    cycle(0, 0, 9'h000, 16'h0, 0);
    do_reset();
    clear_phase(512);
    cycle(1, 0, 9'h0A5, 16'h0, 1);
    cycle(1, 0, 9'h000, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);
    cycle(0, 0, 9'h000, 16'h0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
